// File: rtl/time_setter.sv
// -----------------------------------------------------------------------------
// time_setter
//
// User-programming front end for the egg-timer countdown chain. Debounced
// button levels are turned into BCD minutes:seconds presets. A one-cycle
// load strobe hands the presets to the downcounters, and a run level gates
// their enables. The chain's zero flag raises the alarm.
//
// Optional feature macro: TIME_SETTER_AUTO_REPEAT_EN
//   When it is defined, a held up/down button auto-repeats on tick pulses
//   once REPEAT_DELAY ticks have passed. When it is not defined, only rising
//   edges step a field, and tick is not used.
//
// Parameters
//   REPEAT_DELAY  ticks a held up/down button waits before auto-repeat
//   SEC_TENS_MAX  largest seconds tens digit (field wraps after SEC_TENS_MAX,9)
//   MIN_TENS_MAX  largest minutes tens digit (field wraps after MIN_TENS_MAX,9)
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   tick        in   10 Hz one-cycle enable (auto-repeat only)
//   btn_up      in   debounced level, increment the selected field
//   btn_down    in   debounced level, decrement the selected field
//   btn_sel     in   debounced level, toggle the selected field
//   btn_start   in   debounced level, start / abort
//   zero_count  in   downcounter chain reads 00:00
//   sec_prog    out  BCD seconds preset {tens, ones}
//   min_prog    out  BCD minutes preset {tens, ones}
//   field       out  0 = seconds selected, 1 = minutes selected
//   load        out  one-cycle capture strobe for the downcounters
//   run         out  high while counting
//   alarm       out  high from expiry until a button acknowledges it
//
// All outputs are registered. A button event seen in one cycle shows its
// effect on the outputs at the next clock edge.
// -----------------------------------------------------------------------------
module time_setter #(
    parameter int REPEAT_DELAY = 9,
    parameter int SEC_TENS_MAX = 5,
    parameter int MIN_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       btn_start,
    input  logic       zero_count,
    output logic [7:0] sec_prog,
    output logic [7:0] min_prog,
    output logic       field,
    output logic       load,
    output logic       run,
    output logic       alarm
);

    typedef enum logic [1:0] {
        S_SET   = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TMAX = 4'(SEC_TENS_MAX);
    localparam logic [3:0] MIN_TMAX = 4'(MIN_TENS_MAX);

    // Button bit order used throughout: {start, sel, down, up}
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_SEL   = 2;
    localparam int B_START = 3;

    // -------------------------------------------------------------------------
    // BCD helpers. They use >= compares, so an out-of-range digit (for example
    // after a disturbed register) still moves back into the legal range
    // instead of counting through non-BCD codes.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                           input logic [3:0] tens_max);
        logic [7:0] res;
        if (val[3:0] >= 4'd9) begin
            if (val[7:4] >= tens_max) begin
                res = 8'h00;
            end else begin
                res = {val[7:4] + 4'd1, 4'd0};
            end
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] val,
                                           input logic [3:0] tens_max);
        logic [7:0] res;
        if (val[3:0] == 4'd0) begin
            if ((val[7:4] == 4'd0) || (val[7:4] > tens_max)) begin
                res = {tens_max, 4'd9};
            end else begin
                res = {val[7:4] - 4'd1, 4'd9};
            end
        end else if (val[3:0] > 4'd9) begin
            res = {val[7:4], 4'd9};
        end else begin
            res = {val[7:4], val[3:0] - 4'd1};
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_btn_prev;
    logic [3:0] w_btn_now;
    logic [3:0] w_ev;

    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic       r_field;
    logic       r_load;
    logic       r_run;
    logic       r_alarm;

    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic       w_field_next;
    logic       w_load_next;
    logic       w_run_next;
    logic       w_alarm_next;

    logic       w_step_up;
    logic       w_step_dn;
    logic       w_rpt_up;
    logic       w_rpt_dn;
    logic       w_preset_zero;
    logic       w_any_ev;

    assign w_btn_now     = {btn_start, btn_sel, btn_down, btn_up};
    assign w_ev          = w_btn_now & ~r_btn_prev;
    assign w_any_ev      = |w_ev;
    assign w_preset_zero = (r_sec == 8'h00) && (r_min == 8'h00);

    // Simultaneous up and down edges cancel each other out. Auto-repeat steps
    // can only occur while exactly one of the two buttons is held.
    assign w_step_up = (w_ev[B_UP] & ~w_ev[B_DOWN]) | w_rpt_up;
    assign w_step_dn = (w_ev[B_DOWN] & ~w_ev[B_UP]) | w_rpt_dn;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_DELAY < 2) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_DELAY);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_hold_one;
    logic             w_rpt_clear;
    logic             w_rpt_fire;

    // The count restarts at each fresh up/down edge. It clears when neither
    // button or both buttons are held, and whenever the FSM is outside SET.
    assign w_hold_one  = btn_up ^ btn_down;
    assign w_rpt_clear = (r_state != S_SET) | ~w_hold_one
                       | w_ev[B_UP] | w_ev[B_DOWN];
    assign w_rpt_fire  = tick & ~w_rpt_clear & (r_rpt_cnt == RPT_MAX);
    assign w_rpt_up    = w_rpt_fire & btn_up;
    assign w_rpt_dn    = w_rpt_fire & btn_down;

    // Repeat counter: counts ticks while a single button is held, then saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt_cnt <= '0;
        end else if (w_rpt_clear) begin
            r_rpt_cnt <= '0;
        end else if (tick && (r_rpt_cnt != RPT_MAX)) begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end else begin
            r_rpt_cnt <= r_rpt_cnt;
        end
    end
`else
    logic [1:0] w_unused_cfg;

    assign w_rpt_up     = 1'b0;
    assign w_rpt_dn     = 1'b0;
    assign w_unused_cfg = {tick, 1'(REPEAT_DELAY)};
`endif

    // Button history: one previous-level register per button for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_prev <= 4'b0000;
        end else begin
            r_btn_prev <= w_btn_now;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_SET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_next = r_state;
        w_sec_next   = r_sec;
        w_min_next   = r_min;
        w_field_next = r_field;
        w_load_next  = 1'b0;
        w_run_next   = 1'b0;
        w_alarm_next = 1'b0;

        case (r_state)
            S_SET: begin
                // A step applies to the field selected before this cycle's
                // sel event. That keeps sel+up in one cycle predictable.
                if (r_field) begin
                    if (w_step_up) begin
                        w_min_next = bcd_inc(r_min, MIN_TMAX);
                    end else if (w_step_dn) begin
                        w_min_next = bcd_dec(r_min, MIN_TMAX);
                    end else begin
                        w_min_next = r_min;
                    end
                end else begin
                    if (w_step_up) begin
                        w_sec_next = bcd_inc(r_sec, SEC_TMAX);
                    end else if (w_step_dn) begin
                        w_sec_next = bcd_dec(r_sec, SEC_TMAX);
                    end else begin
                        w_sec_next = r_sec;
                    end
                end

                if (w_ev[B_SEL]) begin
                    w_field_next = ~r_field;
                end else begin
                    w_field_next = r_field;
                end

                // A 00:00 preset would expire at once, so start is ignored.
                if (w_ev[B_START] && !w_preset_zero) begin
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b1;
                end else begin
                    w_state_next = S_SET;
                end
            end

            S_LOAD: begin
                w_state_next = S_RUN;
                w_run_next   = 1'b1;
            end

            S_RUN: begin
                // Expiry takes priority over a coincident abort.
                if (zero_count) begin
                    w_state_next = S_ALARM;
                    w_alarm_next = 1'b1;
                end else if (w_ev[B_START]) begin
                    w_state_next = S_SET;
                end else begin
                    w_state_next = S_RUN;
                    w_run_next   = 1'b1;
                end
            end

            S_ALARM: begin
                // The acknowledging event is consumed and does not step a field.
                if (w_any_ev) begin
                    w_state_next = S_SET;
                end else begin
                    w_state_next = S_ALARM;
                    w_alarm_next = 1'b1;
                end
            end

            default: begin
                w_state_next = S_SET;
            end
        endcase
    end

    // Output registers: presets, field select and control strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sec   <= 8'h00;
            r_min   <= 8'h00;
            r_field <= 1'b0;
            r_load  <= 1'b0;
            r_run   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_sec   <= w_sec_next;
            r_min   <= w_min_next;
            r_field <= w_field_next;
            r_load  <= w_load_next;
            r_run   <= w_run_next;
            r_alarm <= w_alarm_next;
        end
    end

    assign sec_prog = r_sec;
    assign min_prog = r_min;
    assign field    = r_field;
    assign load     = r_load;
    assign run      = r_run;
    assign alarm    = r_alarm;

endmodule
